// File: rtl/axistream_snooper.sv
// AXI Stream receive snooper: writes each incoming packet into a packetmem buffer,
// reports final flit address / byte length, and truncates packets that overflow.
module axistream_snooper #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [63:0]             TDATA,
   input  logic [7:0]              TKEEP,
   input  logic                    TVALID,
   input  logic                    TLAST,
   output logic                    TREADY,
   output logic [ADDR_WIDTH-1:0]   snooper_wr_addr,
   output logic [63:0]             snooper_wr_data,
   output logic                    snooper_wr_en,
   output logic                    snooper_done,
   output logic [ADDR_WIDTH-1:0]   len_from_snooper,
   output logic [ADDR_WIDTH+2:0]   byte_len_from_snooper,
   output logic                    snooper_overflow,
   input  logic                    ready_for_snooper
);

   typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};
   localparam logic [ADDR_WIDTH+2:0] FULL_BYTES = {1'b1, {(ADDR_WIDTH+2){1'b0}}};

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [ADDR_WIDTH+2:0]   byte_cnt;
   logic                    hs;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
      return c;
   endfunction

   assign TREADY = (state == RECV && ready_for_snooper) || state == DROP;
   assign hs     = TVALID && TREADY;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                 <= IDLE;
         addr                  <= '0;
         byte_cnt              <= '0;
         snooper_wr_en         <= 1'b0;
         snooper_wr_addr       <= '0;
         snooper_wr_data       <= '0;
         snooper_done          <= 1'b0;
         len_from_snooper      <= '0;
         byte_len_from_snooper <= '0;
         snooper_overflow      <= 1'b0;
      end else begin
         snooper_wr_en <= 1'b0;
         snooper_done  <= 1'b0;
         case (state)
            IDLE: begin
               addr     <= '0;
               byte_cnt <= '0;
               if (ready_for_snooper) state <= RECV;
            end
            RECV: begin
               if (hs) begin
                  snooper_wr_en   <= 1'b1;
                  snooper_wr_addr <= addr;
                  snooper_wr_data <= TDATA;
                  if (TLAST) begin
                     snooper_done          <= 1'b1;
                     len_from_snooper      <= addr;
                     byte_len_from_snooper <= byte_cnt + (ADDR_WIDTH+3)'(popcount8(TKEEP));
                     snooper_overflow      <= 1'b0;
                     state                 <= IDLE;
                  end else if (addr == LAST_ADDR) begin
                     // buffer is now full; swallow the rest of the packet
                     state <= DROP;
                  end else begin
                     addr     <= addr + ADDR_WIDTH'(2);
                     byte_cnt <= byte_cnt + (ADDR_WIDTH+3)'(8);
                  end
               end
            end
            DROP: begin
               if (hs && TLAST) begin
                  snooper_done          <= 1'b1;
                  len_from_snooper      <= LAST_ADDR;
                  byte_len_from_snooper <= FULL_BYTES;
                  snooper_overflow      <= 1'b1;
                  state                 <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axistream_snooper.sv
// Bench for axistream_snooper: table of packets plus hand sequences for gaps,
// backpressure, reset mid-packet; writes and done reports checked via scoreboard queues.
module tb_axistream_snooper;

   localparam int AW  = 4;
   localparam int CAP = 2 ** (AW - 1);

   logic            clk = 1'b0;
   logic            rst;
   logic [63:0]     TDATA;
   logic [7:0]      TKEEP;
   logic            TVALID;
   logic            TLAST;
   logic            TREADY;
   logic [AW-1:0]   snooper_wr_addr;
   logic [63:0]     snooper_wr_data;
   logic            snooper_wr_en;
   logic            snooper_done;
   logic [AW-1:0]   len_from_snooper;
   logic [AW+2:0]   byte_len_from_snooper;
   logic            snooper_overflow;
   logic            ready_for_snooper;

   axistream_snooper #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst),
      .TDATA(TDATA), .TKEEP(TKEEP), .TVALID(TVALID), .TLAST(TLAST), .TREADY(TREADY),
      .snooper_wr_addr(snooper_wr_addr), .snooper_wr_data(snooper_wr_data),
      .snooper_wr_en(snooper_wr_en), .snooper_done(snooper_done),
      .len_from_snooper(len_from_snooper), .byte_len_from_snooper(byte_len_from_snooper),
      .snooper_overflow(snooper_overflow), .ready_for_snooper(ready_for_snooper)
   );

   always #5 clk = ~clk;

   typedef struct { int addr; logic [63:0] data; int cyc; } wr_t;
   typedef struct { int len; int blen; bit ovf; int cyc; } done_t;
   typedef struct { int n; logic [7:0] keep; int len; int blen; bit ovf; } vec_t;

   wr_t   wq[$];
   done_t dq[$];
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // scoreboard side: compare every write / done the DUT produces
   always @(negedge clk) begin
      if (!rst) begin
         if (snooper_wr_en) begin
            if (wq.size() == 0) chk("unexpected_write", 1, 0);
            else begin
               wr_t w;
               w = wq.pop_front();
               chk("wr_addr", snooper_wr_addr, w.addr);
               chk("wr_data", snooper_wr_data, w.data);
               chk("wr_cycle", cyc, w.cyc);
            end
         end
         if (snooper_done) begin
            if (dq.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               done_t d;
               d = dq.pop_front();
               chk("len", len_from_snooper, d.len);
               chk("byte_len", byte_len_from_snooper, d.blen);
               chk("overflow", snooper_overflow, d.ovf);
               chk("done_cycle", cyc, d.cyc);
               if (!d.ovf) chk("done_with_write", snooper_wr_en, 1);
            end
         end
      end
   end

   // drive one packet; expectations pushed at the moment each flit is accepted
   task automatic send_pkt(input int n, input logic [7:0] keep, input int len, input int blen,
                           input bit ovf, input bit gaps, input int drop_at, input int abort);
      int nf;
      nf = (abort > 0) ? abort : n;
      for (int i = 0; i < nf; i++) begin
         logic [63:0] d;
         int wait_cnt;
         d = {$urandom, $urandom};
         if (gaps && $urandom_range(0, 2) == 0) begin
            TVALID = 1'b0;
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
         end
         TVALID = 1'b1;
         TDATA  = d;
         TLAST  = (i == n - 1);
         TKEEP  = (i == n - 1) ? keep : 8'($urandom);
         if (i == drop_at) begin
            ready_for_snooper = 1'b0;
            repeat (5) begin
               @(negedge clk);
               chk("tready_rfs_low", TREADY, 0);
            end
            @(posedge clk); #1;
            ready_for_snooper = 1'b1;
         end
         wait_cnt = 0;
         forever begin
            @(negedge clk);
            if (TREADY) break;
            if (++wait_cnt > 100) begin
               chk("accept_timeout", 0, 1);
               TVALID = 1'b0;
               return;
            end
         end
         if (i < CAP && !(abort > 0 && i == nf - 1))
            wq.push_back('{addr: 2 * i, data: d, cyc: cyc + 1});
         if (i == n - 1)
            dq.push_back('{len: len, blen: blen, ovf: ovf, cyc: cyc + 1});
         @(posedge clk); #1;
      end
      TVALID = 1'b0;
      TLAST  = 1'b0;
      if (abort == 0) begin
         @(negedge clk);
         chk("idle_gap_tready", TREADY, 0);
      end
   endtask

   vec_t vecs[$];

   initial begin
      vecs = '{
         '{n: 3,  keep: 8'h0F, len: 4,  blen: 20, ovf: 0},
         '{n: 1,  keep: 8'hFF, len: 0,  blen: 8,  ovf: 0},
         '{n: 1,  keep: 8'h81, len: 0,  blen: 2,  ovf: 0},
         '{n: 2,  keep: 8'h00, len: 2,  blen: 8,  ovf: 0},
         '{n: 4,  keep: 8'hA5, len: 6,  blen: 28, ovf: 0},
         '{n: 8,  keep: 8'h01, len: 14, blen: 57, ovf: 0},
         '{n: 12, keep: 8'hFF, len: 14, blen: 64, ovf: 1},
         '{n: 9,  keep: 8'h03, len: 14, blen: 64, ovf: 1}
      };
      rst = 1'b1; TVALID = 1'b0; TLAST = 1'b0; TKEEP = '0; TDATA = '0;
      ready_for_snooper = 1'b1;
      #1;
      chk("rst_tready", TREADY, 0);
      chk("rst_wr_en", snooper_wr_en, 0);
      chk("rst_done", snooper_done, 0);
      chk("rst_len", len_from_snooper, 0);
      chk("rst_byte_len", byte_len_from_snooper, 0);
      chk("rst_overflow", snooper_overflow, 0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk); #1;

      foreach (vecs[k])
         send_pkt(vecs[k].n, vecs[k].keep, vecs[k].len, vecs[k].blen, vecs[k].ovf, 0, -1, 0);

      // random TVALID gaps with packetmem withdrawing the buffer mid-packet
      send_pkt(6, 8'h3F, 10, 46, 0, 1, 3, 0);
      send_pkt(7, 8'hF0, 12, 52, 0, 1, 5, 0);

      // reset between edges after 2 accepted flits: abandoned, no done
      send_pkt(5, 8'hFF, 0, 0, 0, 0, -1, 2);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_wr_en", snooper_wr_en, 0);
      chk("mid_rst_wr_addr", snooper_wr_addr, 0);
      chk("mid_rst_wr_data", snooper_wr_data, 0);
      chk("mid_rst_done", snooper_done, 0);
      chk("mid_rst_tready", TREADY, 0);
      @(posedge clk);
      #3 rst = 1'b0;
      send_pkt(3, 8'h0F, 4, 20, 0, 0, -1, 0);

      // no buffer for 20 cycles while upstream is pushing
      ready_for_snooper = 1'b0;
      TVALID = 1'b1; TDATA = 64'hDEAD_BEEF_0000_0001; TLAST = 1'b1; TKEEP = 8'hFF;
      repeat (20) begin
         @(negedge clk);
         chk("no_buf_tready", TREADY, 0);
         chk("no_buf_wr_en", snooper_wr_en, 0);
      end
      TVALID = 1'b0; TLAST = 1'b0;
      ready_for_snooper = 1'b1;
      send_pkt(2, 8'hFF, 2, 16, 0, 0, -1, 0);

      repeat (4) @(posedge clk);
      chk("writes_drained", wq.size(), 0);
      chk("dones_drained", dq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
